// File: rtl/latch_mem_wb_skid.sv
// MEM/WB pipeline latch with a valid/ready handshake and two-entry skid storage.
// The head entry drives the write-back port and the WB->EX forwarding compare.
// The skid entry absorbs the one extra entry that can arrive while WB stalls,
// so the upstream in_ready never depends combinationally on out_ready.
module latch_mem_wb_skid #(
    parameter int B      = 32,
    parameter int W      = 5,
    parameter bit FWD_R0 = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    // MEM-side handshake and payload
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [B-1:0] read_data_in,
    input  logic [B-1:0] alu_result_in,
    input  logic [W-1:0] mux_RegDst_in,
    input  logic         wb_RegWrite_in,
    input  logic         wb_MemtoReg_in,
    // WB-side handshake and payload
    output logic         out_valid,
    input  logic         out_ready,
    output logic [B-1:0] read_data_out,
    output logic [B-1:0] alu_result_out,
    output logic [W-1:0] mux_RegDst_out,
    output logic         wb_RegWrite_out,
    output logic         wb_MemtoReg_out,
    output logic [B-1:0] wb_data_out,
    // forwarding compare against EX source addresses
    input  logic [W-1:0] fwd_rs_in,
    input  logic [W-1:0] fwd_rt_in,
    output logic         fwd_rs_hit,
    output logic         fwd_rt_hit
);

    // Entry layout, LSB first: read data, ALU result, destination, MemtoReg, RegWrite.
    localparam int E      = 2*B + W + 2;
    localparam int RD_LO  = 0;
    localparam int ALU_LO = B;
    localparam int DST_LO = 2*B;
    localparam int M2R    = 2*B + W;
    localparam int RW     = 2*B + W + 1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic [E-1:0] r_head;
    logic [E-1:0] r_skid;
    logic [E-1:0] w_in_entry;

    logic w_in_fire;
    logic w_out_fire;
    logic w_load_head_in;
    logic w_load_head_skid;
    logic w_load_skid;

    assign w_in_entry = {wb_RegWrite_in, wb_MemtoReg_in, mux_RegDst_in,
                         alu_result_in, read_data_in};

    // Ready and valid come straight from the state register, never from out_ready.
    assign in_ready   = (r_state != ST_FULL) & ~reset;
    assign out_valid  = (r_state != ST_EMPTY);
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    // Next-state and data-load decisions; an entry offered during flush is dropped.
    always_comb begin
        w_state_next     = r_state;
        w_load_head_in   = 1'b0;
        w_load_head_skid = 1'b0;
        w_load_skid      = 1'b0;
        unique case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_state_next   = ST_ONE;
                    w_load_head_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_state_next   = ST_ONE;
                    w_load_head_in = 1'b1;
                end else if (w_in_fire) begin
                    w_state_next = ST_FULL;
                    w_load_skid  = 1'b1;
                end else if (w_out_fire) begin
                    w_state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_out_fire) begin
                    w_state_next     = ST_ONE;
                    w_load_head_skid = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_EMPTY;
            end
        endcase
        if (flush) begin
            w_state_next     = ST_EMPTY;
            w_load_head_in   = 1'b0;
            w_load_head_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
    end

    // State register; reset takes priority over flush (flush is folded into next state).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Head and skid payload registers; cleared on reset, left stale on flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_head_in) begin
                r_head <= w_in_entry;
            end else if (w_load_head_skid) begin
                r_head <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_in_entry;
            end
        end
    end

    assign read_data_out   = r_head[RD_LO  +: B];
    assign alu_result_out  = r_head[ALU_LO +: B];
    assign mux_RegDst_out  = r_head[DST_LO +: W];
    assign wb_MemtoReg_out = r_head[M2R];
    // A bubble must never write the register file.
    assign wb_RegWrite_out = r_head[RW] & out_valid;
    assign wb_data_out     = wb_MemtoReg_out ? read_data_out : alu_result_out;

    // Forwarding compare: one identical comparator per EX source port.
    // Only the head is compared; EX hazard logic stalls on anything still in skid.
    logic [W-1:0] w_fwd_addr [2];
    logic [1:0]   w_fwd_hit;

    assign w_fwd_addr[0] = fwd_rs_in;
    assign w_fwd_addr[1] = fwd_rt_in;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            logic w_addr_zero;
            assign w_addr_zero   = (w_fwd_addr[gi] == '0);
            assign w_fwd_hit[gi] = wb_RegWrite_out
                                 & (mux_RegDst_out == w_fwd_addr[gi])
                                 & ~(FWD_R0 & w_addr_zero);
        end
    endgenerate

    assign fwd_rs_hit = w_fwd_hit[0];
    assign fwd_rt_hit = w_fwd_hit[1];

endmodule

// File: tb/tb_latch_mem_wb_skid.sv
// Directed bench for latch_mem_wb_skid: accepted entries go into a scoreboard
// queue and are compared in order whenever WB consumes the head.
module tb_latch_mem_wb_skid;

    localparam int B = 32;
    localparam int W = 5;

    logic         clk = 1'b0;
    logic         reset, flush;
    logic         in_valid, in_ready;
    logic [B-1:0] read_data_in, alu_result_in;
    logic [W-1:0] mux_RegDst_in;
    logic         wb_RegWrite_in, wb_MemtoReg_in;
    logic         out_valid, out_ready;
    logic [B-1:0] read_data_out, alu_result_out, wb_data_out;
    logic [W-1:0] mux_RegDst_out;
    logic         wb_RegWrite_out, wb_MemtoReg_out;
    logic [W-1:0] fwd_rs_in, fwd_rt_in;
    logic         fwd_rs_hit, fwd_rt_hit;

    latch_mem_wb_skid #(.B(B), .W(W), .FWD_R0(1'b1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .read_data_in(read_data_in), .alu_result_in(alu_result_in),
        .mux_RegDst_in(mux_RegDst_in), .wb_RegWrite_in(wb_RegWrite_in),
        .wb_MemtoReg_in(wb_MemtoReg_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .read_data_out(read_data_out), .alu_result_out(alu_result_out),
        .mux_RegDst_out(mux_RegDst_out), .wb_RegWrite_out(wb_RegWrite_out),
        .wb_MemtoReg_out(wb_MemtoReg_out), .wb_data_out(wb_data_out),
        .fwd_rs_in(fwd_rs_in), .fwd_rt_in(fwd_rt_in),
        .fwd_rs_hit(fwd_rs_hit), .fwd_rt_hit(fwd_rt_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [B-1:0] data;
        logic [W-1:0] dst;
        logic         rw;
        logic         m2r;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive(input logic v, input logic [B-1:0] rd, input logic [B-1:0] alu,
                         input logic [W-1:0] dst, input logic rw, input logic m2r);
        in_valid       = v;
        read_data_in   = rd;
        alu_result_in  = alu;
        mux_RegDst_in  = dst;
        wb_RegWrite_in = rw;
        wb_MemtoReg_in = m2r;
    endtask

    // One clock: at the falling edge, score a consumed head and record an accepted input.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", {32'h0, wb_data_out}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("wb_data",     {32'h0, wb_data_out}, {32'h0, e.data});
                check("dst",         {59'h0, mux_RegDst_out}, {59'h0, e.dst});
                check("regwrite",    {63'h0, wb_RegWrite_out}, {63'h0, e.rw});
                check("memtoreg",    {63'h0, wb_MemtoReg_out}, {63'h0, e.m2r});
            end
        end
        if (reset || flush) begin
            sb.delete();
        end else if (in_valid && in_ready) begin
            e.data = wb_MemtoReg_in ? read_data_in : alu_result_in;
            e.dst  = mux_RegDst_in;
            e.rw   = wb_RegWrite_in;
            e.m2r  = wb_MemtoReg_in;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        fwd_rs_in = '0; fwd_rt_in = '0;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);

        // Reset held for two cycles
        @(posedge clk); #1;
        in_valid = 1'b1;
        #1;
        check("rst_in_ready",  {63'h0, in_ready}, 64'h0);
        check("rst_out_valid", {63'h0, out_valid}, 64'h0);
        check("rst_wb_data",   {32'h0, wb_data_out}, 64'h0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("post_rst_in_ready",  {63'h0, in_ready}, 64'h1);
        check("post_rst_out_valid", {63'h0, out_valid}, 64'h0);
        check("post_rst_dst",       {59'h0, mux_RegDst_out}, 64'h0);
        check("post_rst_rw",        {63'h0, wb_RegWrite_out}, 64'h0);
        check("post_rst_alu",       {32'h0, alu_result_out}, 64'h0);
        check("post_rst_rd",        {32'h0, read_data_out}, 64'h0);

        // Streaming at full throughput
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 32'h0, i, 5'(i), 1'b1, 1'b0);
            #1;
            if (i > 1) check("stream_no_gap", {63'h0, out_valid}, 64'h1);
            cycle();
        end
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        cycle();
        check("stream_drained", {63'h0, out_valid}, 64'h0);
        check("stream_sb_empty", 64'(sb.size()), 64'h0);

        // Back-pressure fills head and skid
        out_ready = 1'b0;
        drive(1'b1, 32'h0, 32'hA, 5'd10, 1'b1, 1'b0); cycle();
        drive(1'b1, 32'h0, 32'hB, 5'd11, 1'b1, 1'b0); cycle();
        drive(1'b1, 32'h0, 32'hC, 5'd12, 1'b1, 1'b0);
        #1;
        check("full_in_ready",  {63'h0, in_ready}, 64'h0);
        check("full_out_valid", {63'h0, out_valid}, 64'h1);
        check("full_head",      {32'h0, wb_data_out}, 64'hA);
        cycle();
        check("full_hold_in_ready", {63'h0, in_ready}, 64'h0);
        check("full_hold_head",     {32'h0, wb_data_out}, 64'hA);
        out_ready = 1'b1;
        cycle();
        cycle();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        cycle();
        check("bp_drained", {63'h0, out_valid}, 64'h0);
        check("bp_sb_empty", 64'(sb.size()), 64'h0);

        // MemtoReg select
        out_ready = 1'b0;
        drive(1'b1, 32'hDEAD, 32'hBEEF, 5'd3, 1'b1, 1'b1); cycle();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        #1;
        check("m2r_one", {32'h0, wb_data_out}, 64'hDEAD);
        out_ready = 1'b1; cycle();
        out_ready = 1'b0;
        drive(1'b1, 32'hDEAD, 32'hBEEF, 5'd3, 1'b1, 1'b0); cycle();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        #1;
        check("m2r_zero", {32'h0, wb_data_out}, 64'hBEEF);
        out_ready = 1'b1; cycle();

        // Forwarding compare
        out_ready = 1'b0;
        drive(1'b1, 32'h0, 32'h55, 5'd5, 1'b1, 1'b0); cycle();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        fwd_rs_in = 5'd5; fwd_rt_in = 5'd6;
        #1;
        check("fwd_rs_hit5", {63'h0, fwd_rs_hit}, 64'h1);
        check("fwd_rt_miss6", {63'h0, fwd_rt_hit}, 64'h0);
        fwd_rs_in = 5'd6; fwd_rt_in = 5'd5;
        #1;
        check("fwd_rt_hit5", {63'h0, fwd_rt_hit}, 64'h1);
        check("fwd_rs_miss6", {63'h0, fwd_rs_hit}, 64'h0);
        out_ready = 1'b1; cycle();
        out_ready = 1'b0;
        fwd_rs_in = 5'd5; fwd_rt_in = 5'd5;
        #1;
        check("fwd_invalid_rw", {63'h0, wb_RegWrite_out}, 64'h0);
        check("fwd_invalid_rs", {63'h0, fwd_rs_hit}, 64'h0);
        check("fwd_invalid_rt", {63'h0, fwd_rt_hit}, 64'h0);
        drive(1'b1, 32'h0, 32'h66, 5'd0, 1'b1, 1'b0); cycle();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        fwd_rs_in = 5'd0; fwd_rt_in = 5'd0;
        #1;
        check("fwd_r0_rw", {63'h0, wb_RegWrite_out}, 64'h1);
        check("fwd_r0_rs", {63'h0, fwd_rs_hit}, 64'h0);
        check("fwd_r0_rt", {63'h0, fwd_rt_hit}, 64'h0);
        out_ready = 1'b1; cycle();

        // Flush while FULL with an entry offered
        out_ready = 1'b0;
        drive(1'b1, 32'h0, 32'h11, 5'd1, 1'b1, 1'b0); cycle();
        drive(1'b1, 32'h0, 32'h22, 5'd2, 1'b1, 1'b0); cycle();
        drive(1'b1, 32'h0, 32'h33, 5'd3, 1'b1, 1'b0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        #1;
        check("flush_full_valid", {63'h0, out_valid}, 64'h0);
        check("flush_full_ready", {63'h0, in_ready}, 64'h1);
        check("flush_full_rw",    {63'h0, wb_RegWrite_out}, 64'h0);
        // Flush in ONE discards an accepted-looking entry in the same cycle
        drive(1'b1, 32'h0, 32'h44, 5'd4, 1'b1, 1'b0); cycle();
        drive(1'b1, 32'h0, 32'h55, 5'd5, 1'b1, 1'b0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        #1;
        check("flush_one_valid", {63'h0, out_valid}, 64'h0);
        out_ready = 1'b1;
        drive(1'b1, 32'h0, 32'h66, 5'd6, 1'b1, 1'b0); cycle();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        cycle();
        check("flush_after_empty", {63'h0, out_valid}, 64'h0);
        check("flush_sb_empty", 64'(sb.size()), 64'h0);

        // Reset mid-operation loses held entries and clears outputs
        out_ready = 1'b0;
        drive(1'b1, 32'h77, 32'h88, 5'd7, 1'b1, 1'b1); cycle();
        drive(1'b1, 32'h99, 32'hAA, 5'd9, 1'b1, 1'b0); cycle();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check("midrst_in_ready", {63'h0, in_ready}, 64'h0);
        cycle();
        check("midrst_valid", {63'h0, out_valid}, 64'h0);
        check("midrst_wb",    {32'h0, wb_data_out}, 64'h0);
        check("midrst_rd",    {32'h0, read_data_out}, 64'h0);
        check("midrst_alu",   {32'h0, alu_result_out}, 64'h0);
        check("midrst_m2r",   {63'h0, wb_MemtoReg_out}, 64'h0);
        reset = 1'b0;
        #1;
        check("midrst_ready_after", {63'h0, in_ready}, 64'h1);
        out_ready = 1'b1;
        cycle();
        check("midrst_no_ghost", {63'h0, out_valid}, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
